ram_access_sequencer: RTL
=========================

RAM_ACCESS_SEQUENCER -- requirements
Module: ram_access_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, meaning host byte-address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum number of cycles to wait for MEM_ACK before aborting (range 2..255).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ADDR, input, ADDR_W bits: host byte address.
REQ-006 SHALL have port DIN, input, 16 bits: host write data.
REQ-007 SHALL have port DIN_SIZE, input, 1 bit: write size (0 = 8-bit, 1 = 16-bit).
REQ-008 SHALL have ports OE_n / WE_n / RFSH_n, inputs, 1 bit each: level-held host read, write and refresh strobes, all active-low.
REQ-009 SHALL have port DOUT, output, 16 bits: host read data.
REQ-010 SHALL have port WAIT_n, output, 1 bit: host stall, active-low.
REQ-011 SHALL have port ERR, output, 1 bit: sticky timeout flag.
REQ-012 SHALL have memory-side outputs MEM_REQ (1), MEM_WE (1), MEM_RFSH (1), MEM_ADDR (ADDR_W-1), MEM_WDATA (16) and MEM_BE (2).
REQ-013 SHALL have memory-side inputs MEM_ACK (1) and MEM_RDATA (16); MEM_RDATA is valid in the cycle MEM_ACK=1.

Function
REQ-014 SHALL detect each strobe's falling edge as a registered previous value = 1 and a current value = 0.
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, REFRESH and HOLD.
REQ-016 In IDLE, a WE_n edge SHALL go to WRITE; otherwise an OE_n edge SHALL go to READ; otherwise a pending refresh SHALL go to REFRESH.
REQ-017 Simultaneous WE_n and OE_n edges: the write SHALL be taken and the read discarded.
REQ-018 On entry to READ, WRITE or REFRESH, the block SHALL latch ADDR, DIN and DIN_SIZE.
REQ-019 On entry to READ, WRITE or REFRESH, the block SHALL assert MEM_REQ from the next cycle, held until the MEM_ACK cycle, and clear it in the following cycle.
REQ-020 The address SHALL map as MEM_ADDR = latched ADDR[ADDR_W-1:1].
REQ-021 16-bit write: MEM_BE = 2'b11 and MEM_WDATA = DIN.
REQ-022 8-bit write: MEM_BE = ADDR[0] ? 2'b10 : 2'b01, and MEM_WDATA = {DIN[7:0], DIN[7:0]}.
REQ-023 READ SHALL capture DOUT on MEM_ACK: ADDR[0]=0 -> MEM_RDATA; ADDR[0]=1 -> {8'h00, MEM_RDATA[15:8]}.
REQ-024 DOUT SHALL hold its captured value until the next read capture.
REQ-025 REFRESH SHALL assert MEM_REQ and MEM_RFSH together, with MEM_WE=0 and MEM_BE=0.
REQ-026 An RFSH_n edge in any state SHALL set a pending flag, cleared on entry to REFRESH; multiple edges while pending SHALL collapse to one.
REQ-027 WAIT_n SHALL be a registered output, 0 from the cycle after a host READ/WRITE start until the cycle after MEM_ACK, else 1.
REQ-028 REFRESH SHALL NOT drive WAIT_n low.
REQ-029 After a host access completes, the FSM SHALL go to HOLD if the originating strobe is still low, else to IDLE.
REQ-030 HOLD SHALL return to IDLE when the originating strobe is high; a strobe held low SHALL never retrigger.
REQ-031 A strobe released mid-access SHALL NOT abort it: the memory cycle completes, then IDLE.
REQ-032 A cycle counter SHALL count MEM_REQ cycles; at TIMEOUT_CYC without MEM_ACK the block SHALL drop MEM_REQ, set ERR=1 and, for a read, set DOUT=16'hFFFF.
REQ-033 After a timeout, the FSM SHALL proceed as in REQ-029.
REQ-034 Edges arriving during READ/WRITE/HOLD SHALL be ignored, except RFSH_n per REQ-026.

Reset
REQ-035 On RESET=1, asynchronously: state = IDLE; MEM_REQ, MEM_WE and MEM_RFSH = 0; MEM_ADDR, MEM_WDATA and MEM_BE = 0; DOUT = 0; WAIT_n = 1; ERR = 0; pending = 0; strobe history registers = 1.
REQ-036 RESET mid-access SHALL abandon the memory cycle with no completion.
REQ-037 After RESET, a strobe that is already low SHALL NOT start an access until it goes high and falls again.

Verification
REQ-038 Scenario: ADDR=0x000101, OE_n falls, MEM_ACK 3 cycles after MEM_REQ with MEM_RDATA=0xA55A -> MEM_ADDR=0x000080, DOUT=0x00A5, WAIT_n returns to 1 the cycle after ACK.
REQ-039 Scenario: 8-bit write, ADDR=0x000003, DIN=0x0042 -> MEM_BE=2'b10, MEM_WDATA=0x4242, MEM_WE=1.
REQ-040 Scenario: WE_n and OE_n fall in the same cycle -> a single write, no read request.
REQ-041 Scenario: RFSH_n pulses twice during a 10-cycle read -> after HOLD exits, exactly one REFRESH with MEM_RFSH=1 and WAIT_n=1 throughout.
REQ-042 Scenario: MEM_ACK never asserted on a read -> after 64 cycles MEM_REQ=0, ERR=1, DOUT=0xFFFF, WAIT_n=1.
REQ-043 Scenario: RESET asserted mid-write while WE_n stays low -> all outputs at reset values; no new request until WE_n rises and falls again.

Source files
------------

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: turns level-held, active-low host strobes (read, write,
// refresh) into single request/acknowledge cycles on a 16-bit word memory.
// Byte addressing on the host side is folded into a word address plus byte
// enables. Host accesses stall the host through WAIT_n. A stuck memory is
// released by a cycle-count timeout that raises a sticky ERR flag.
//
// Memory handshake: MEM_REQ rises in the cycle after the sequencer commits to
// an access and stays high, with MEM_WE/MEM_RFSH/MEM_ADDR/MEM_WDATA/MEM_BE
// stable, until the cycle in which MEM_ACK=1. That cycle is the transfer:
// MEM_RDATA is sampled there, and MEM_REQ is low in the following cycle.
// MEM_ACK is ignored while MEM_REQ is low.
module ram_access_sequencer #(
    parameter int ADDR_W      = 22,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       DIN,
    input  logic              DIN_SIZE,
    input  logic              OE_n,
    input  logic              WE_n,
    input  logic              RFSH_n,
    output logic [15:0]       DOUT,
    output logic              WAIT_n,
    output logic              ERR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic              MEM_RFSH,
    output logic [ADDR_W-2:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    output logic [1:0]        MEM_BE,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_RDATA,
    output logic [2:0]        DBG_STATE
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_REFRESH = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // Last request cycle that may still see MEM_ACK before the access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d;
    logic       oe_q, we_q, rfsh_q;
    logic       hist_valid_q;
    logic       pending_q;
    logic       hold_wr_q;
    logic       addr_lsb_q;
    logic [7:0] cnt_q;

    logic       oe_fall, we_fall, rfsh_fall;
    logic       tmo_hit, finish;
    logic       start_rd, start_wr, start_rf, start_any;
    logic       origin_high;

    // The first cycle after reset only loads the strobe history, so a strobe
    // that is already low when reset drops cannot look like a fresh edge.
    assign oe_fall   = hist_valid_q & oe_q   & ~OE_n;
    assign we_fall   = hist_valid_q & we_q   & ~WE_n;
    assign rfsh_fall = hist_valid_q & rfsh_q & ~RFSH_n;

    assign tmo_hit     = (cnt_q == TMO_LAST);
    assign finish      = MEM_REQ & (MEM_ACK | tmo_hit);
    assign start_any   = start_rd | start_wr | start_rf;
    assign origin_high = hold_wr_q ? WE_n : OE_n;
    assign DBG_STATE   = state_q;

    // Strobe history, edge qualification and the collapsing refresh-pending flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            oe_q         <= 1'b1;
            we_q         <= 1'b1;
            rfsh_q       <= 1'b1;
            hist_valid_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            oe_q         <= OE_n;
            we_q         <= WE_n;
            rfsh_q       <= RFSH_n;
            hist_valid_q <= 1'b1;
            pending_q    <= (pending_q & ~start_rf) | rfsh_fall;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: write beats read beats refresh; host accesses park in HOLD.
    always_comb begin
        state_d  = state_q;
        start_rd = 1'b0;
        start_wr = 1'b0;
        start_rf = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (we_fall) begin
                    state_d  = ST_WRITE;
                    start_wr = 1'b1;
                end else if (oe_fall) begin
                    state_d  = ST_READ;
                    start_rd = 1'b1;
                end else if (pending_q) begin
                    state_d  = ST_REFRESH;
                    start_rf = 1'b1;
                end
            end
            ST_READ: begin
                if (finish) state_d = OE_n ? ST_IDLE : ST_HOLD;
            end
            ST_WRITE: begin
                if (finish) state_d = WE_n ? ST_IDLE : ST_HOLD;
            end
            ST_REFRESH: begin
                if (finish) state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (origin_high) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side request, byte lanes, host read data, stall and timeout tracking.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MEM_REQ    <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_RFSH   <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
            MEM_BE     <= '0;
            DOUT       <= '0;
            WAIT_n     <= 1'b1;
            ERR        <= 1'b0;
            cnt_q      <= '0;
            addr_lsb_q <= 1'b0;
            hold_wr_q  <= 1'b0;
        end else if (start_any) begin
            MEM_REQ    <= 1'b1;
            MEM_WE     <= start_wr;
            MEM_RFSH   <= start_rf;
            MEM_ADDR   <= ADDR[ADDR_W-1:1];
            addr_lsb_q <= ADDR[0];
            hold_wr_q  <= start_wr;
            cnt_q      <= '0;
            WAIT_n     <= ~(start_wr | start_rd);
            if (start_rf) begin
                MEM_BE <= 2'b00;
            end else if (start_rd || DIN_SIZE) begin
                MEM_BE <= 2'b11;
            end else begin
                MEM_BE <= ADDR[0] ? 2'b10 : 2'b01;
            end
            if (start_wr) begin
                MEM_WDATA <= DIN_SIZE ? DIN : {DIN[7:0], DIN[7:0]};
            end
        end else if (MEM_REQ) begin
            if (MEM_ACK || tmo_hit) begin
                MEM_REQ  <= 1'b0;
                MEM_WE   <= 1'b0;
                MEM_RFSH <= 1'b0;
                WAIT_n   <= 1'b1;
                if (!MEM_ACK) begin
                    ERR <= 1'b1;
                end
                if (state_q == ST_READ) begin
                    if (!MEM_ACK) begin
                        DOUT <= 16'hFFFF;
                    end else if (addr_lsb_q) begin
                        DOUT <= {8'h00, MEM_RDATA[15:8]};
                    end else begin
                        DOUT <= MEM_RDATA;
                    end
                end
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule
